btb_update_scheduler: RTL and testbench
=======================================

// Module: btb_update_scheduler
// PURPOSE
//  Collects branch-target-buffer update requests from several producers (branch units,
//  decode-stage corrections) and issues them to the BTB one per cycle.
//  - Queues requests so that producers are never blocked by a single-port BTB write.
//  - Holds off all updates while the BTB runs its post-reset clear sweep.
//  - Inserts a one-cycle gap after each "multiple" update, so the BTB's deferred
//    multiple-bit write always commits.
//  - Merges back-to-back identical requests.
// PARAMETERS
//  NUM_SRC      2              number of update producers
//  QUEUE_DEPTH  4              FIFO entries, power of two, >=2
//  INIT_CYCLES  `BTB_ENTRIES   cycles after reset during which the BTB clears itself
// PORTS
//  clk          in   1                 clock
//  rst          in   1                 asynchronous reset, active-high
//  IN_upd       in   NUM_SRC x BTUpdate   per-source request; .valid is the request
//  OUT_ready    out  NUM_SRC           per-source accept; transfer = IN_upd[i].valid && OUT_ready[i]
//  OUT_btUpdate out  BTUpdate          update to BTB, registered; .valid qualifies it
//  OUT_busy     out  1                 1 while the init sweep is running
//  OUT_merged   out  1                 1-cycle pulse when an accepted request is merged, not queued
// BEHAVIOUR
//  Reset (async, rst=1)
//   - Clears queue (count=0, ptrs=0), rr=0, bubble=0, initCnt=0.
//   - OUT_btUpdate.valid=0, OUT_ready=0, OUT_merged=0, OUT_busy=1.
//   - Assertion mid-operation discards all queued and in-flight updates; no partial issue.
//  Init
//   - initCnt counts from the first clk edge after rst deasserts.
//   - While initCnt<INIT_CYCLES: OUT_busy=1, OUT_ready=0, no issue.
//   - OUT_busy falls in cycle INIT_CYCLES after reset release.
//  Accept (at most one per cycle, combinational grant)
//   - Grant goes to the first valid source at or after rr, in circular order.
//   - OUT_ready[g]=1 only for the granted source, only when !busy and count<QUEUE_DEPTH.
//   - No full bypass: a full queue refuses even if a dequeue happens the same cycle.
//   - After a transfer, rr <= (g+1) mod NUM_SRC. rr is unchanged when nothing transfers.
//   - Merge: the request is accepted but not enqueued, and OUT_merged=1 next cycle, when
//     count>0 and the request equals the youngest queued entry in all of:
//     src, dst, btype, compressed, clean, multiple, multipleOffs, fetchStartOffs.
//   - A request is never merged against an entry already issued.
//  Issue
//   - Issue happens on a clock edge when count>0 (post-update of this cycle not
//     considered) and bubble=0. Then OUT_btUpdate <= head, head pops, count decrements.
//   - Otherwise OUT_btUpdate.valid <= 0.
//   - Latency: request accepted in cycle t into an empty queue appears on OUT_btUpdate in
//     cycle t+2.
//   - If the issued entry has multiple=1 and clean=0, bubble <= 1. The next cycle issues
//     nothing and clears bubble. Net effect: at least one idle BTB cycle between it and any
//     following update.
//   - Simultaneous enqueue and issue in one cycle: count is unchanged, ptrs both advance.
//   - Pointers are $clog2(QUEUE_DEPTH) bits and wrap naturally. Count is one bit wider.
//   - Issue order equals accept order (FIFO). Merged requests never reorder.
// TESTING
//  1. Reset, INIT_CYCLES=8, src0 valid from cycle 0 -> OUT_ready[0]=0 for cycles 0..7;
//     accepted in cycle 8; OUT_btUpdate.valid in cycle 10.
//  2. Both sources valid continuously with distinct src -> grants alternate 0,1,0,1;
//     OUT_btUpdate shows the same order, one per cycle.
//  3. Issue with multiple=1, clean=0, then a second queued entry -> OUT valid, then 0 for
//     one cycle, then the second entry. Same stimulus with clean=1 -> no gap.
//  4. Same request presented 2 cycles back-to-back while the first is still queued ->
//     second accepted, OUT_merged=1, and exactly one BTB update issued.
//  5. Stall issue by a bubble chain, fill 4 entries -> OUT_ready all 0 with count=4;
//     ptrs wrap after 5+ ops; order preserved.
//  6. Assert rst with 3 entries queued -> OUT_btUpdate.valid=0 immediately; after release
//     OUT_busy=1 again and no stale entry is ever issued.

Source files
------------

// File: rtl/btb_update_scheduler.sv
// BTB update scheduler: arbitrates producer update requests into a small FIFO and
// issues one update per cycle, honouring the init sweep, multiple-write gaps and merges.

`ifndef BTB_ENTRIES
`define BTB_ENTRIES 1024
`endif

module btb_update_scheduler #(
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned INIT_CYCLES = `BTB_ENTRIES,
  // Flat BTUpdate layout, MSB first:
  // valid[75] src[74:43] dst[42:11] btype[10:9] compressed[8] clean[7] multiple[6]
  // multipleOffs[5:3] fetchStartOffs[2:0]
  localparam int unsigned UPD_W      = 76
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*UPD_W-1:0] IN_upd,
  output logic [NUM_SRC-1:0]       OUT_ready,
  output logic [UPD_W-1:0]         OUT_btUpdate,
  output logic                     OUT_busy,
  output logic                     OUT_merged
);

  localparam int unsigned KEY_W     = UPD_W - 1;
  localparam int unsigned VALID_BIT = UPD_W - 1;
  localparam int unsigned CLEAN_BIT = 7;
  localparam int unsigned MULT_BIT  = 6;
  localparam int unsigned PTR_W     = $clog2(QUEUE_DEPTH);
  localparam int unsigned SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned INIT_W    = $clog2(INIT_CYCLES + 1);

  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES);
  localparam logic [PTR_W:0]    FULL      = (PTR_W + 1)'(QUEUE_DEPTH);

  logic [UPD_W-1:0]  req [NUM_SRC];

  logic [KEY_W-1:0]  mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]  rptr_q, wptr_q;
  logic [PTR_W:0]    count_q;
  logic [SRC_W-1:0]  rr_q;
  logic              bubble_q;
  logic [INIT_W-1:0] init_cnt_q;
  logic              out_valid_q;
  logic [KEY_W-1:0]  out_data_q;
  logic              merged_q;

  logic              busy;
  logic              grant_valid;
  logic [SRC_W-1:0]  grant_idx;
  logic [SRC_W-1:0]  cand;
  logic              xfer;
  logic              merge;
  logic              enq;
  logic              issue;
  logic [KEY_W-1:0]  grant_key;
  logic [KEY_W-1:0]  head;
  logic [KEY_W-1:0]  youngest;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_req
    assign req[s] = IN_upd[s*UPD_W +: UPD_W];
  end

  assign busy = (init_cnt_q != INIT_LAST);

  // Round-robin: first valid source at or after rr_q, circularly.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cand = SRC_W'((32'(rr_q) + i) % NUM_SRC);
      if (!grant_valid && req[cand][VALID_BIT]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant_key = req[grant_idx][KEY_W-1:0];
  assign head      = mem_q[rptr_q];
  assign youngest  = mem_q[wptr_q - PTR_W'(1)];

  // Full queue refuses regardless of a same-cycle dequeue.
  assign xfer  = grant_valid && !busy && (count_q != FULL);
  assign merge = xfer && (count_q != '0) && (grant_key == youngest);
  assign enq   = xfer && !merge;
  assign issue = !busy && (count_q != '0) && !bubble_q;

  always_comb begin
    OUT_ready = '0;
    if (xfer) begin
      OUT_ready[grant_idx] = 1'b1;
    end
  end

  assign OUT_btUpdate = {out_valid_q, out_data_q};
  assign OUT_busy     = busy;
  assign OUT_merged   = merged_q;

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wptr_q] <= grant_key;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q      <= '0;
      wptr_q      <= '0;
      count_q     <= '0;
      rr_q        <= '0;
      bubble_q    <= 1'b0;
      init_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      merged_q    <= 1'b0;
    end else begin
      if (busy) begin
        init_cnt_q <= init_cnt_q + INIT_W'(1);
      end

      if (issue) begin
        out_valid_q <= 1'b1;
        out_data_q  <= head;
        rptr_q      <= rptr_q + PTR_W'(1);
        // Give the BTB an idle cycle to commit its deferred multiple-bit write.
        bubble_q    <= head[MULT_BIT] && !head[CLEAN_BIT];
      end else begin
        out_valid_q <= 1'b0;
        bubble_q    <= 1'b0;
      end

      if (enq) begin
        wptr_q <= wptr_q + PTR_W'(1);
      end

      unique case ({enq, issue})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase

      if (xfer) begin
        rr_q <= (32'(grant_idx) == NUM_SRC - 1) ? '0 : grant_idx + SRC_W'(1);
      end

      merged_q <= merge;
    end
  end

endmodule

// File: tb/tb_btb_update_scheduler.sv
// Directed bench for btb_update_scheduler: queue-based reference model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.

module tb_btb_update_scheduler;

  localparam int NSRC  = 2;
  localparam int DEPTH = 4;
  localparam int INIT  = 8;
  localparam int W     = 76;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [W-1:0]    in_req [NSRC];
  logic [NSRC*W-1:0] in_upd;
  logic [NSRC-1:0] out_ready;
  logic [W-1:0]    out_upd;
  logic            out_busy;
  logic            out_merged;

  assign in_upd = {in_req[1], in_req[0]};

  btb_update_scheduler #(
    .NUM_SRC    (NSRC),
    .QUEUE_DEPTH(DEPTH),
    .INIT_CYCLES(INIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .IN_upd      (in_upd),
    .OUT_ready   (out_ready),
    .OUT_btUpdate(out_upd),
    .OUT_busy    (out_busy),
    .OUT_merged  (out_merged)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  int           m_init;
  int           m_rr;
  bit           m_bubble;
  bit           m_out_v;
  logic [W-2:0] m_out_d;
  bit           m_merged;
  logic [W-2:0] m_q [$];

  // Values sampled mid-cycle by tick()
  logic [NSRC-1:0] s_rdy;
  logic            s_outv;
  logic [31:0]     s_src;
  logic            s_merged;
  logic            s_busy;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] mk(input int src, input int dst, input bit mult,
                                      input bit clean);
    logic [W-1:0] u;
    u        = '0;
    u[75]    = 1'b1;
    u[74:43] = src;
    u[42:11] = dst;
    u[10:9]  = 2'd1;
    u[7]     = clean;
    u[6]     = mult;
    u[5:3]   = 3'(dst);
    u[2:0]   = 3'(src);
    return u;
  endfunction

  task automatic model_reset();
    m_init   = 0;
    m_rr     = 0;
    m_bubble = 0;
    m_out_v  = 0;
    m_out_d  = '0;
    m_merged = 0;
    m_q.delete();
  endtask

  task automatic model_step(input int g);
    bit           busy;
    bit           issue;
    bit           merge;
    logic [W-2:0] key;
    busy  = (m_init < INIT);
    issue = !busy && (m_q.size() > 0) && !m_bubble;
    merge = 0;
    key   = '0;
    if (g >= 0) begin
      key   = in_req[g][W-2:0];
      merge = (m_q.size() > 0) && (m_q[$] == key);
    end
    if (issue) begin
      m_out_d  = m_q.pop_front();
      m_out_v  = 1;
      m_bubble = m_out_d[6] && !m_out_d[7];
    end else begin
      m_out_v  = 0;
      m_bubble = 0;
    end
    m_merged = 0;
    if (g >= 0) begin
      if (merge) m_merged = 1;
      else m_q.push_back(key);
      m_rr = (g + 1) % NSRC;
    end
    if (m_init < INIT) m_init++;
  endtask

  // One cycle: compare mid-cycle, advance model on the edge, return just after it.
  task automatic tick();
    int              g;
    bit              exp_busy;
    logic [NSRC-1:0] exp_rdy;
    @(negedge clk);
    exp_busy = (m_init < INIT);
    g        = -1;
    if (!rst && !exp_busy && m_q.size() < DEPTH) begin
      for (int i = 0; i < NSRC; i++) begin
        int k;
        k = (m_rr + i) % NSRC;
        if (g < 0 && in_req[k][W-1]) g = k;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("ready", W'(out_ready), W'(exp_rdy));
    check("busy", W'(out_busy), W'(exp_busy));
    check("merged", W'(out_merged), W'(m_merged));
    check("out_valid", W'(out_upd[W-1]), W'(m_out_v));
    if (m_out_v) check("out_data", W'(out_upd[W-2:0]), W'(m_out_d));
    s_rdy    = out_ready;
    s_outv   = out_upd[W-1];
    s_src    = out_upd[74:43];
    s_merged = out_merged;
    s_busy   = out_busy;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(g);
    #1;
  endtask

  task automatic idle();
    in_req[0] = '0;
    in_req[1] = '0;
  endtask

  task automatic reset_and_init();
    idle();
    rst = 1'b1;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    repeat (INIT) tick();
  endtask

  task automatic gap_test(input bit clean);
    logic        ov [5];
    logic [31:0] os [5];
    reset_and_init();
    in_req[0] = mk(30, 300, 1'b1, clean);
    tick();
    ov[0] = s_outv;
    os[0] = s_src;
    in_req[0] = mk(31, 310, 1'b0, 1'b1);
    tick();
    ov[1] = s_outv;
    os[1] = s_src;
    idle();
    for (int c = 2; c < 5; c++) begin
      tick();
      ov[c] = s_outv;
      os[c] = s_src;
    end
    check("gap_c2_valid", W'(ov[2]), W'(1));
    check("gap_c2_src", W'(os[2]), W'(30));
    check("gap_c3_valid", W'(ov[3]), W'(clean));
    check("gap_second_src", W'(clean ? os[3] : os[4]), W'(31));
    check("gap_c4_valid", W'(ov[4]), W'(!clean));
    repeat (3) tick();
  endtask

  initial begin
    int          n_upd;
    int          n_mrg;
    int          next;
    logic [31:0] order [$];

    model_reset();
    idle();

    // 1: init sweep holds off accept; first accept visible two cycles later
    tick();
    tick();
    rst = 1'b0;
    in_req[0] = mk(10, 100, 1'b0, 1'b1);
    for (int c = 0; c < INIT; c++) begin
      tick();
      check($sformatf("init_rdy_c%0d", c), W'(s_rdy), W'(0));
      check($sformatf("init_busy_c%0d", c), W'(s_busy), W'(1));
    end
    tick();
    check("init_rdy_c8", W'(s_rdy), W'(2'b01));
    check("init_busy_c8", W'(s_busy), W'(0));
    idle();
    tick();
    check("lat_c9_valid", W'(s_outv), W'(0));
    tick();
    check("lat_c10_valid", W'(s_outv), W'(1));
    check("lat_c10_src", W'(s_src), W'(10));
    repeat (2) tick();

    // 2: round-robin alternation, issued in accept order
    reset_and_init();
    in_req[0] = mk(20, 200, 1'b0, 1'b1);
    in_req[1] = mk(21, 210, 1'b0, 1'b1);
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("rr_rdy_c%0d", c), W'(s_rdy), W'((c % 2 == 0) ? 2'b01 : 2'b10));
      if (c >= 2) begin
        check($sformatf("rr_out_c%0d", c), W'({s_outv, s_src}),
              W'({1'b1, ((c % 2 == 0) ? 32'd20 : 32'd21)}));
      end
    end
    idle();
    repeat (4) tick();

    // 3: multiple/dirty issue inserts a gap, clean one does not
    gap_test(1'b0);
    gap_test(1'b1);

    // 4: back-to-back identical request merges into one BTB update
    reset_and_init();
    n_upd = 0;
    n_mrg = 0;
    in_req[0] = mk(40, 400, 1'b0, 1'b1);
    for (int c = 0; c < 6; c++) begin
      if (c == 2) idle();
      tick();
      n_upd += int'(s_outv);
      n_mrg += int'(s_merged);
      if (c == 1) check("merge_c1_rdy", W'(s_rdy), W'(2'b01));
      if (c == 2) check("merge_c2_pulse", W'(s_merged), W'(1));
    end
    check("merge_updates", W'(n_upd), W'(1));
    check("merge_pulses", W'(n_mrg), W'(1));

    // 5: bubble chain backs the queue up to full; order survives pointer wrap
    reset_and_init();
    next = 0;
    order.delete();
    for (int c = 0; c < 40; c++) begin
      if (next < 10) in_req[0] = mk(50 + next, 500 + next, 1'b1, 1'b0);
      else idle();
      tick();
      if (c == 6) check("full_c6_rdy", W'(s_rdy), W'(2'b01));
      if (c == 7) check("full_c7_rdy", W'(s_rdy), W'(0));
      if (s_rdy[0] && next < 10) next++;
      if (s_outv) order.push_back(s_src);
    end
    check("fifo_count", W'(order.size()), W'(10));
    for (int i = 0; i < order.size(); i++) begin
      check($sformatf("fifo_order_%0d", i), W'(order[i]), W'(50 + i));
    end

    // 6: reset with entries queued drops everything, init sweep restarts
    reset_and_init();
    for (int c = 0; c < 6; c++) begin
      in_req[0] = mk(60 + c, 600 + c, 1'b1, 1'b0);
      tick();
    end
    idle();
    check("rst_pre_valid", W'(out_upd[W-1]), W'(1));
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_valid", W'(out_upd[W-1]), W'(0));
    check("rst_async_busy", W'(out_busy), W'(1));
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    n_upd = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (c == 0) check("rst_rel_busy", W'(s_busy), W'(1));
      if (c == INIT) check("rst_rel_busy_c8", W'(s_busy), W'(0));
      n_upd += int'(s_outv);
    end
    check("rst_no_stale", W'(n_upd), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
